// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and state type for the serial pattern detector
package seq_det_pkg;
  localparam int DEF_PATTERN_LEN = 3;
  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_PATTERN_LEN-1:0] DEF_RESET_PATTERN = 3'b101;
  typedef enum logic {FILLING, ARMED} det_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with sticky saturation flag and clear
import seq_det_pkg::*;
module sat_counter #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  logic [CNT_W-1:0] count_d, count_q;
  logic sat_d, sat_q;
  always_comb begin
    count_d = clr ? (inc ? CNT_W'(1) : '0) : (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
    sat_d = !clr && (sat_q || (inc && (&count_q)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      sat_q <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q <= sat_d;
    end
  end
  assign count = count_q;
  assign sat = sat_q;
endmodule

// File: rtl/seq_detector.sv
// seq_detector: programmable serial bit-pattern detector with overlap control and match counter
import seq_det_pkg::*;
module seq_detector #(
  parameter int                     PATTERN_LEN   = DEF_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] RESET_PATTERN = PATTERN_LEN'(DEF_RESET_PATTERN),
  parameter int                     CNT_W         = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data,
  input  logic                   data_valid,
  input  logic [PATTERN_LEN-1:0] pattern,
  input  logic                   pattern_load,
  input  logic                   overlap,
  input  logic                   count_clr,
  output logic                   out,
  output logic [CNT_W-1:0]       match_count,
  output logic                   count_sat
);
  localparam int FW = $clog2(PATTERN_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN);
  logic [PATTERN_LEN-1:0] hist_d, hist_q, pat_d, pat_q, hist_nxt;
  logic [FW-1:0] fill_d, fill_q, fill_nxt;
  logic out_d, out_q, accept, match;
  det_state_e state;
  always_comb begin
    accept = data_valid && !pattern_load;
    state = (fill_q == FULL) ? ARMED : FILLING;
    hist_nxt = {hist_q[PATTERN_LEN-2:0], data};
    fill_nxt = (state == ARMED) ? FULL : fill_q + 1'b1;
    match = accept && (fill_nxt == FULL) && (hist_nxt == pat_q);
    pat_d = pattern_load ? pattern : pat_q;
    hist_d = pattern_load ? '0 : accept ? hist_nxt : hist_q;
    fill_d = pattern_load ? '0 : !accept ? fill_q : (match && !overlap) ? '0 : fill_nxt;
    out_d = match;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q <= RESET_PATTERN;
      out_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q <= pat_d;
      out_q <= out_d;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (count_clr),
    .inc  (match),
    .count(match_count),
    .sat  (count_sat)
  );
  assign out = out_q;
endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: table-driven scoreboard bench for seq_detector with a 2-bit counter
module tb_seq_detector;
  typedef struct packed {
    logic rst, d, vld, ld;
    logic [2:0] pat;
    logic ov, clr, eo;
    logic [1:0] ec;
    logic es;
  } vec_t;
  typedef struct packed {
    logic eo;
    logic [1:0] ec;
    logic es;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1, data = 1'b0, data_valid = 1'b0, pattern_load = 1'b0, overlap = 1'b1, count_clr = 1'b0;
  logic [2:0] pattern = 3'b000;
  logic out, count_sat;
  logic [1:0] match_count;
  int n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  vec_t tbl[$];
  always #5 clk = ~clk;
  seq_detector #(.PATTERN_LEN(3), .RESET_PATTERN(3'b101), .CNT_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .data_valid  (data_valid),
    .pattern     (pattern),
    .pattern_load(pattern_load),
    .overlap     (overlap),
    .count_clr   (count_clr),
    .out         (out),
    .match_count (match_count),
    .count_sat   (count_sat)
  );
  function automatic vec_t mk(logic rst, logic d, logic vld, logic ld, logic [2:0] pat, logic ov, logic clr,
                              logic eo, logic [1:0] ec, logic es);
    return '{rst: rst, d: d, vld: vld, ld: ld, pat: pat, ov: ov, clr: clr, eo: eo, ec: ec, es: es};
  endfunction
  task automatic step(input vec_t t, input string name);
    exp_t e;
    @(negedge clk);
    reset = t.rst;
    data = t.d;
    data_valid = t.vld;
    pattern_load = t.ld;
    pattern = t.pat;
    overlap = t.ov;
    count_clr = t.clr;
    sb.push_back('{eo: t.eo, ec: t.ec, es: t.es});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({out, match_count, count_sat} !== e) begin
      n_bad++;
      $display("FAIL %s: out/count/sat got %b/%0d/%b want %b/%0d/%b",
               name, out, match_count, count_sat, e.eo, e.ec, e.es);
    end
  endtask
  initial begin
    // overlap on, default pattern 101: stream 1,0,1,0,1
    tbl.push_back(mk(1,0,0,0,3'b000,1,0, 0,2'd0,0));
    tbl.push_back(mk(0,1,1,0,3'b000,1,0, 0,2'd0,0));
    tbl.push_back(mk(0,0,1,0,3'b000,1,0, 0,2'd0,0));
    tbl.push_back(mk(0,1,1,0,3'b000,1,0, 1,2'd1,0));
    tbl.push_back(mk(0,0,1,0,3'b000,1,0, 0,2'd1,0));
    tbl.push_back(mk(0,1,1,0,3'b000,1,0, 1,2'd2,0));
    tbl.push_back(mk(0,0,0,0,3'b000,1,0, 0,2'd2,0));
    // overlap off: same stream
    tbl.push_back(mk(1,0,0,0,3'b000,0,0, 0,2'd0,0));
    tbl.push_back(mk(0,1,1,0,3'b000,0,0, 0,2'd0,0));
    tbl.push_back(mk(0,0,1,0,3'b000,0,0, 0,2'd0,0));
    tbl.push_back(mk(0,1,1,0,3'b000,0,0, 1,2'd1,0));
    tbl.push_back(mk(0,0,1,0,3'b000,0,0, 0,2'd1,0));
    tbl.push_back(mk(0,1,1,0,3'b000,0,0, 0,2'd1,0));
    tbl.push_back(mk(0,0,0,0,3'b000,0,0, 0,2'd1,0));
    // valid gaps (data=1 while invalid must be ignored)
    tbl.push_back(mk(1,0,0,0,3'b000,1,0, 0,2'd0,0));
    tbl.push_back(mk(0,1,1,0,3'b000,1,0, 0,2'd0,0));
    tbl.push_back(mk(0,1,0,0,3'b000,1,0, 0,2'd0,0));
    tbl.push_back(mk(0,0,1,0,3'b000,1,0, 0,2'd0,0));
    tbl.push_back(mk(0,1,0,0,3'b000,1,0, 0,2'd0,0));
    tbl.push_back(mk(0,1,0,0,3'b000,1,0, 0,2'd0,0));
    tbl.push_back(mk(0,1,1,0,3'b000,1,0, 1,2'd1,0));
    tbl.push_back(mk(0,1,0,0,3'b000,1,0, 0,2'd1,0));
    foreach (tbl[i]) step(tbl[i], $sformatf("tbl[%0d]", i));
    // pattern reload colliding with an accepted bit that would otherwise match 101
    step(mk(1,0,0,0,3'b000,1,0, 0,2'd0,0), "ld_rst");
    step(mk(0,1,1,0,3'b000,1,0, 0,2'd0,0), "ld_pre1");
    step(mk(0,0,1,0,3'b000,1,0, 0,2'd0,0), "ld_pre0");
    step(mk(0,1,1,1,3'b111,1,0, 0,2'd0,0), "ld_collide");
    step(mk(0,1,1,0,3'b000,1,0, 0,2'd0,0), "ld_b1");
    step(mk(0,1,1,0,3'b000,1,0, 0,2'd0,0), "ld_b2");
    step(mk(0,1,1,0,3'b000,1,0, 1,2'd1,0), "ld_b3");
    step(mk(0,1,1,0,3'b000,1,0, 1,2'd2,0), "ld_b4");
    step(mk(0,0,0,0,3'b000,1,0, 0,2'd2,0), "ld_idle");
    // saturation of the 2-bit counter, then clear coinciding with a match
    step(mk(1,0,0,0,3'b000,1,0, 0,2'd0,0), "sat_rst");
    step(mk(0,1,1,0,3'b000,1,0, 0,2'd0,0), "sat_b1");
    step(mk(0,0,1,0,3'b000,1,0, 0,2'd0,0), "sat_b2");
    step(mk(0,1,1,0,3'b000,1,0, 1,2'd1,0), "sat_m1");
    step(mk(0,0,1,0,3'b000,1,0, 0,2'd1,0), "sat_b4");
    step(mk(0,1,1,0,3'b000,1,0, 1,2'd2,0), "sat_m2");
    step(mk(0,0,1,0,3'b000,1,0, 0,2'd2,0), "sat_b6");
    step(mk(0,1,1,0,3'b000,1,0, 1,2'd3,0), "sat_m3");
    step(mk(0,0,1,0,3'b000,1,0, 0,2'd3,0), "sat_b8");
    step(mk(0,1,1,0,3'b000,1,0, 1,2'd3,1), "sat_m4");
    step(mk(0,0,0,0,3'b000,1,0, 0,2'd3,1), "sat_hold");
    step(mk(0,0,1,0,3'b000,1,0, 0,2'd3,1), "sat_b10");
    step(mk(0,1,1,0,3'b000,1,1, 1,2'd1,0), "sat_clr_m5");
    step(mk(0,0,0,0,3'b000,1,1, 0,2'd0,0), "sat_clr_only");
    // reset mid-pattern with a simultaneous load that must lose to reset
    step(mk(1,0,0,0,3'b000,1,0, 0,2'd0,0), "mid_rst0");
    step(mk(0,1,1,0,3'b000,1,0, 0,2'd0,0), "mid_b1");
    step(mk(0,0,1,0,3'b000,1,0, 0,2'd0,0), "mid_b0");
    step(mk(1,1,1,1,3'b111,1,0, 0,2'd0,0), "mid_rst");
    step(mk(0,1,1,0,3'b000,1,0, 0,2'd0,0), "mid_after1");
    step(mk(0,0,1,0,3'b000,1,0, 0,2'd0,0), "mid_after0");
    step(mk(0,1,1,0,3'b000,1,0, 1,2'd1,0), "mid_match");
    step(mk(0,0,0,0,3'b000,1,0, 0,2'd1,0), "mid_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial bit-pattern detector, the successor to the fixed three-bit FSM detector. It watches a qualified serial bit stream and pulses `out` whenever the last `PATTERN_LEN` accepted bits equal a run-time programmable pattern. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits directly on a serial data line alongside the existing single-pattern detectors and replaces them where the pattern must change at run time.

## Interface
- `PATTERN_LEN`, 3: pattern length in bits, at least 2.
- `RESET_PATTERN`, 3'b101: pattern register value after reset, `PATTERN_LEN` bits wide.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `data`  in  1: serial bit.
- `data_valid`  in  1: `data` is accepted on this cycle.
- `pattern`  in  `PATTERN_LEN`: new pattern; the MSB is the first bit in time.
- `pattern_load`  in  1: load `pattern` into the pattern register.
- `overlap`  in  1: 1 selects overlapping detection, 0 selects non-overlapping.
- `count_clr`  in  1: clear `match_count` and `count_sat`.
- `out`  out  1: one-cycle match pulse.
- `match_count`  out  `CNT_W`: number of matches, saturating.
- `count_sat`  out  1: sticky flag; `match_count` has saturated.

## Operation
- The history shift register `hist` updates on an accepted bit: `hist <= {hist[PATTERN_LEN-2:0], data}`.
- Fill counter `fill` runs 0..`PATTERN_LEN`, increments per accepted bit and saturates at `PATTERN_LEN`.
- Match condition: accepted bit and fill reaching `PATTERN_LEN` and the next `hist` equals the pattern register.
- States:
  - FILLING: `fill < PATTERN_LEN`.
  - ARMED: `fill == PATTERN_LEN`.
  - A match in overlap=1 mode stays in ARMED.
  - A match in overlap=0 mode sets `fill` to 0 (FILLING), so the matched bits are not reused.
- `overlap` is sampled on each accepted bit, so a mode change applies from the next bit.
- `pattern_load` loads the pattern register and also clears `hist` and `fill`.
  - If it coincides with `data_valid`, the load wins and the bit is discarded.
  - A load produces no `out` pulse on that cycle.
- Counter:
  - A match increments `match_count`.
  - At all-ones, `match_count` holds and `count_sat` is set.
  - `count_sat` stays set until `count_clr` or `reset`.
  - `count_clr` together with a match gives `match_count = 1` and `count_sat = 0`; the match is not lost.
- Cycles with `data_valid` = 0 change nothing: the history is held, gaps are transparent, and `out` = 0.

## Timing
- `reset`, sampled high on an edge, sets the following:
  - `out` = 0, `match_count` = 0, `count_sat` = 0.
  - `hist` = 0 and `fill` = 0.
  - The pattern register is set to `RESET_PATTERN`.
- `reset` has priority over every other input.
- Reset during a partially received pattern discards the partial history; a full `PATTERN_LEN` bits are needed after reset before any match.
- Latency is 1 cycle. `out` is registered and high on the cycle after the edge that accepted the final pattern bit. It is never high for two consecutive cycles unless consecutive accepted bits each complete a match.
- `match_count` updates on the same edge that raises `out`.
- `count_sat` rises on the edge where an increment is attempted at all-ones, which is one increment after the counter reaches all-ones.
- `pattern_load` takes effect on the next edge, and the new pattern applies to bits accepted after that edge.

## Structure
- Package `seq_det_pkg`:
  - default constants `DEF_PATTERN_LEN`, `DEF_CNT_W`, `DEF_RESET_PATTERN`;
  - a typedef for the FILLING/ARMED state enum.
- Sub-module `sat_counter`: parameter `CNT_W`; inputs `clk`, `reset`, `clr`, `inc`; outputs `count` and `sat`. It implements the clear-plus-increment rule above.
- The top level holds `hist`, `fill`, the pattern register, the match logic and the `out` register.

## Test plan
- **Overlap on (default pattern).** After reset with `PATTERN_LEN` = 3 and overlap=1, feed 1,0,1,0,1 with valid every cycle. Expect `out` pulses one cycle after bit 3 and after bit 5, and `match_count` = 2.
- **Overlap off.** Same stream with overlap=0. Expect a single pulse after bit 3 and `match_count` = 1.
- **Pattern reload with collision.** Load pattern 3'b111 in the same cycle as `data_valid` = 1 with `data` = 1, then feed 1,1,1,1. Expect the colliding bit to be ignored, pulses after bits 3 and 4, and `match_count` = 2.
- **Valid gaps.** Feed 1, gap, 0, gap, gap, 1 with pattern 101. Expect exactly one pulse, on the cycle after the final accepted 1.
- **Saturation and clear.** With `CNT_W` = 2, produce 4 matches. Expect `match_count` = 3 and `count_sat` = 1. Then assert `count_clr` together with a 5th match; expect `match_count` = 1 and `count_sat` = 0.
- **Reset mid-pattern.** Feed 1,0, assert `reset` for 1 cycle, then feed 1. Expect no pulse, all outputs 0, and the pattern register equal to `RESET_PATTERN`.
